// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the M-stage load/store unit (master) and memory (slave).
// The master holds req with stable addr/we/be/wdata until gnt; read data returns on rvalid.
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: turns an execute-stage memory op into one req/gnt/rvalid access,
// stalls the pipeline until it completes, and returns byte/half/word load data extended to 32 bits.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ValidX,
  input  logic                   MemWriteX,
  input  logic                   MemReadX,
  input  logic [2:0]             Funct3X,
  input  logic [31:0]            ALUResultX,
  input  logic [31:0]            RD2X,
  output logic                   StallM,
  output logic [31:0]            ReadDataM,
  output logic                   LoadValidM,
  output logic                   MisalignM,
  output logic                   TimeoutM,
  mem_stage_lsu_if.master        mem
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t             state;
  logic               load_p1;
  logic [1:0]         off_p1;
  logic [2:0]         f3_p1;
  logic [CNT_W-1:0]   cnt;

  logic               start;
  logic               legal;
  logic               expired;

  function automatic logic access_legal(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = !(rd && wr);
    case (f3)
      3'b000, 3'b100: ok = ok;
      3'b001, 3'b101: if (off[0]) ok = 1'b0;
      3'b010:         if (off != 2'b00) ok = 1'b0;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane select by byte offset, then sign- or zero-extend on funct3[2].
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = 32'($signed(b));
      3'b100:  r = {24'b0, b};
      3'b001:  r = 32'($signed(h));
      3'b101:  r = {16'b0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign start   = (state == IDLE) && ValidX && (MemReadX || MemWriteX);
  assign legal   = access_legal(MemReadX, MemWriteX, Funct3X, ALUResultX[1:0]);
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign StallM  = (start && legal) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mem.req    <= 1'b0;
      mem.we     <= 1'b0;
      mem.be     <= 4'b0;
      mem.addr   <= 32'b0;
      mem.wdata  <= 32'b0;
      ReadDataM  <= 32'b0;
      LoadValidM <= 1'b0;
      MisalignM  <= 1'b0;
      TimeoutM   <= 1'b0;
      cnt        <= '0;
      load_p1    <= 1'b0;
      off_p1     <= 2'b0;
      f3_p1      <= 3'b0;
    end else begin
      LoadValidM <= 1'b0;
      MisalignM  <= 1'b0;
      TimeoutM   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !legal) begin
            MisalignM <= 1'b1;
          end else if (start) begin
            // X -> M boundary: the access is captured here; X inputs are ignored until IDLE again.
            state     <= REQ;
            mem.req   <= 1'b1;
            mem.we    <= MemWriteX;
            mem.addr  <= {ALUResultX[31:2], 2'b00};
            mem.be    <= MemWriteX ? store_be(Funct3X[1:0], ALUResultX[1:0]) : 4'b1111;
            mem.wdata <= store_wdata(Funct3X[1:0], RD2X);
            cnt       <= '0;
            load_p1   <= MemReadX;
            off_p1    <= ALUResultX[1:0];
            f3_p1     <= Funct3X;
          end
        end
        REQ: begin
          if (mem.gnt && (!load_p1 || mem.rvalid)) begin
            state   <= IDLE;
            mem.req <= 1'b0;
            if (load_p1) begin
              ReadDataM  <= load_extend(mem.rdata, off_p1, f3_p1);
              LoadValidM <= 1'b1;
            end
          end else if (expired) begin
            state    <= IDLE;
            mem.req  <= 1'b0;
            TimeoutM <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (mem.gnt) begin
              state   <= RESP;
              mem.req <= 1'b0;
            end
          end
        end
        RESP: begin
          if (mem.rvalid) begin
            state      <= IDLE;
            ReadDataM  <= load_extend(mem.rdata, off_p1, f3_p1);
            LoadValidM <= 1'b1;
          end else if (expired) begin
            state    <= IDLE;
            TimeoutM <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem.req <= 1'b0;
        end
      endcase
    end
  end

endmodule
